vend_dispenser: RTL

- Output stage downstream of the credit-state latch. Consumes the latched credit state and a debounced vend-request level.
- When credit is sufficient, runs a timed dispense sequence: product LED, then one change pulse per unit of change owed, then a one-cycle credit-clear strobe back to the state latch.
- Drives the change seven-segment display with the change still owed.

---
 rtl/vend_dispenser_if.sv | 25 ++
 rtl/vend_dispenser.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/vend_dispenser_if.sv
// Bundle of credit/request inputs and dispense outputs between the
// controller side (master) and the vend_dispenser output stage (slave).
interface vend_dispenser_if;
    logic [3:0] credit;
    logic       vendReq;
    logic       productLED;
    logic       changePulse;
    logic       denyLED;
    logic       clearCredit;
    logic       busy;
    logic [3:0] changeOwed;
    logic [6:0] changeDisplay;

    modport master (
        output credit, vendReq,
        input  productLED, changePulse, denyLED, clearCredit, busy,
               changeOwed, changeDisplay
    );

    modport slave (
        input  credit, vendReq,
        output productLED, changePulse, denyLED, clearCredit, busy,
               changeOwed, changeDisplay
    );
endinterface

// File: rtl/vend_dispenser.sv
// Vend output stage: on a rising vend request either dispenses (product LED,
// one change pulse per unit owed, credit-clear strobe) or flashes deny.
// A single down-counter times every state; all outputs are registered.
module vend_dispenser #(
    parameter int PRICE       = 4,
    parameter int VEND_CYCLES = 25_000_000,
    parameter int PULSE_HIGH  = 12_500_000,
    parameter int PULSE_GAP   = 12_500_000,
    parameter int DENY_CYCLES = 50_000_000
) (
    input  logic             clk,
    input  logic             reset,
    vend_dispenser_if.slave  bus
);

    // Counter only ever holds (duration - 1), so ceil(log2(max)) bits suffice.
    localparam int MAX_A   = (VEND_CYCLES > PULSE_HIGH) ? VEND_CYCLES : PULSE_HIGH;
    localparam int MAX_B   = (PULSE_GAP > DENY_CYCLES) ? PULSE_GAP : DENY_CYCLES;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] VEND_LD = CNT_W'(VEND_CYCLES - 1);
    localparam logic [CNT_W-1:0] HIGH_LD = CNT_W'(PULSE_HIGH - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(PULSE_GAP - 1);
    localparam logic [CNT_W-1:0] DENY_LD = CNT_W'(DENY_CYCLES - 1);
    localparam logic [3:0]       PRICE_V = 4'(PRICE);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        VEND    = 3'd1,
        PULSE_H = 3'd2,
        PULSE_L = 3'd3,
        DONE    = 3'd4,
        DENY    = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       owed_q, owed_d;
    logic             vend_req_q, vend_req_d;
    logic             product_led_q, product_led_d;
    logic             change_pulse_q, change_pulse_d;
    logic             deny_led_q, deny_led_d;
    logic             clear_credit_q, clear_credit_d;
    logic             busy_q, busy_d;
    logic             start;

    // Active-low hex digit, bit0 = segment a ... bit6 = segment g.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_to_seg = 7'b1000000;
            4'h1: hex_to_seg = 7'b1111001;
            4'h2: hex_to_seg = 7'b0100100;
            4'h3: hex_to_seg = 7'b0110000;
            4'h4: hex_to_seg = 7'b0011001;
            4'h5: hex_to_seg = 7'b0010010;
            4'h6: hex_to_seg = 7'b0000010;
            4'h7: hex_to_seg = 7'b1111000;
            4'h8: hex_to_seg = 7'b0000000;
            4'h9: hex_to_seg = 7'b0010000;
            4'hA: hex_to_seg = 7'b0001000;
            4'hB: hex_to_seg = 7'b0000011;
            4'hC: hex_to_seg = 7'b1000110;
            4'hD: hex_to_seg = 7'b0100001;
            4'hE: hex_to_seg = 7'b0000110;
            default: hex_to_seg = 7'b0001110;
        endcase
    endfunction

    // Rising edge of the debounced request; ignored unless idle.
    assign start      = bus.vendReq & ~vend_req_q;
    assign vend_req_d = bus.vendReq;

    // Next state, shared counter reload on entry, and change bookkeeping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owed_d  = owed_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (bus.credit >= PRICE_V) begin
                        state_d = VEND;
                        cnt_d   = VEND_LD;
                        owed_d  = bus.credit - PRICE_V;
                    end else begin
                        state_d = DENY;
                        cnt_d   = DENY_LD;
                    end
                end
            end
            VEND: begin
                if (cnt_q == '0) begin
                    if (owed_q == 4'd0) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        state_d = PULSE_H;
                        cnt_d   = HIGH_LD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            PULSE_H: begin
                if (cnt_q == '0) begin
                    state_d = PULSE_L;
                    cnt_d   = GAP_LD;
                    owed_d  = owed_q - 4'd1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            PULSE_L: begin
                if (cnt_q == '0) begin
                    if (owed_q == 4'd0) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        state_d = PULSE_H;
                        cnt_d   = HIGH_LD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            DENY: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decoded from the upcoming state so each asserts on its state's first cycle.
    always_comb begin
        product_led_d  = (state_d == VEND);
        change_pulse_d = (state_d == PULSE_H);
        deny_led_d     = (state_d == DENY);
        clear_credit_d = (state_d == DONE);
        busy_d         = (state_d != IDLE);
    end

    // State, counter, change owed and request history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            owed_q     <= 4'd0;
            vend_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owed_q     <= owed_d;
            vend_req_q <= vend_req_d;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            product_led_q  <= 1'b0;
            change_pulse_q <= 1'b0;
            deny_led_q     <= 1'b0;
            clear_credit_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            product_led_q  <= product_led_d;
            change_pulse_q <= change_pulse_d;
            deny_led_q     <= deny_led_d;
            clear_credit_q <= clear_credit_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.productLED    = product_led_q;
    assign bus.changePulse   = change_pulse_q;
    assign bus.denyLED       = deny_led_q;
    assign bus.clearCredit   = clear_credit_q;
    assign bus.busy          = busy_q;
    assign bus.changeOwed    = owed_q;
    assign bus.changeDisplay = hex_to_seg(owed_q);

endmodule
